// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_write_arbiter_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned REG_ADDR_WIDTH = $clog2(NUM_REGS);
  localparam int unsigned NUM_WB_SRC     = 3;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_CSR  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter  int unsigned N  = NUM_WB_SRC,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          stall_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int unsigned j;
    logic [IW-1:0] sel;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    sel     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr_i < N, so a single conditional subtract wraps without a modulo.
      j = 32'(ptr_i) + k;
      if (j >= N) j = j - N;
      sel = IW'(j);
      if (!stall_i && !found && req_i[sel]) begin
        grant_o[sel] = 1'b1;
        idx_o        = sel;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the single register-file write port between writeback
// sources; registers the accepted write and drives the bank's one-hot enables.
module regfile_write_arbiter #(
  parameter  int unsigned NUM_REQ    = regfile_write_arbiter_pkg::NUM_WB_SRC,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_REGS   = regfile_write_arbiter_pkg::NUM_REGS,
  parameter  int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  parameter  int unsigned CNT_WIDTH  = 16,
  localparam int unsigned SRC_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 stall,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REGS-1:0]                  wr_enable,
  output logic [DATA_WIDTH-1:0]                wr_data,
  output logic [SRC_WIDTH-1:0]                 wr_src,
  output logic [CNT_WIDTH-1:0]                 wr_count
);

  logic [NUM_REQ-1:0]    grant;
  logic [SRC_WIDTH-1:0]  gidx;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [SRC_WIDTH-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [NUM_REGS-1:0]   wr_enable_q, wr_enable_d;
  logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
  logic [SRC_WIDTH-1:0]  wr_src_q,    wr_src_d;
  logic [CNT_WIDTH-1:0]  wr_count_q,  wr_count_d;

  // Holding the arbiter stalled during reset keeps req_ready low throughout.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .stall_i (stall | ~reset),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_addr  = req_addr[gidx];
  assign sel_data  = req_data[gidx];

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wr_enable_d = '0;
    wr_data_d   = wr_data_q;
    wr_src_d    = wr_src_q;
    wr_count_d  = wr_count_q;
    if (xfer) begin
      rr_ptr_d  = (gidx == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : gidx + SRC_WIDTH'(1);
      wr_data_d = sel_data;
      wr_src_d  = gidx;
      if (sel_addr != '0) begin
        wr_enable_d = NUM_REGS'(1) << sel_addr;
        if (wr_count_q != '1) wr_count_d = wr_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      wr_enable_q <= '0;
      wr_data_q   <= '0;
      wr_src_q    <= '0;
      wr_count_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_enable_q <= wr_enable_d;
      wr_data_q   <= wr_data_d;
      wr_src_q    <= wr_src_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign wr_enable = wr_enable_q;
  assign wr_data   = wr_data_q;
  assign wr_src    = wr_src_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter against a
// transaction-level reference model.
module tb_regfile_write_arbiter;

  localparam int NQ = 3;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   stall = 1'b0;
  logic [NQ-1:0]          req_valid = '0;
  logic [NQ-1:0]          req_ready;
  logic [NQ-1:0][AW-1:0]  req_addr = '0;
  logic [NQ-1:0][DW-1:0]  req_data = '0;
  logic [NR-1:0]          wr_enable;
  logic [DW-1:0]          wr_data;
  logic [1:0]             wr_src;
  logic [CW-1:0]          wr_count;

  regfile_write_arbiter #(
    .NUM_REQ    (NQ),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_enable (wr_enable),
    .wr_data   (wr_data),
    .wr_src    (wr_src),
    .wr_count  (wr_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: the last committed write and the priority pointer.
  logic [NR-1:0] m_en;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_cnt;
  int            m_ptr;
  int            last_g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_en = '0; m_data = '0; m_src = 0; m_cnt = 0; m_ptr = 0;
  endfunction

  function automatic logic [NQ-1:0] model_grant();
    logic [NQ-1:0] g;
    int idx;
    g = '0;
    if (!reset || stall) return g;
    for (int k = 0; k < NQ; k++) begin
      idx = (m_ptr + k) % NQ;
      if (req_valid[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic cycle(input bit chk);
    logic [NQ-1:0] eg;
    #1;
    eg = model_grant();
    if (chk) begin
      check("req_ready", 64'(req_ready), 64'(eg));
      check("wr_enable", 64'(wr_enable), 64'(m_en));
      check("wr_data",   64'(wr_data),   64'(m_data));
      check("wr_src",    64'(wr_src),    64'(m_src));
      check("wr_count",  64'(wr_count),  64'(m_cnt));
    end
    @(posedge clock);
    last_g = -1;
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < NQ; i++) if (eg[i]) last_g = i;
      if (last_g >= 0) begin
        m_en   = (req_addr[last_g] != 0) ? (NR'(1) << req_addr[last_g]) : '0;
        m_data = req_data[last_g];
        m_src  = last_g;
        if (req_addr[last_g] != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
        m_ptr  = (last_g + 1) % NQ;
      end else begin
        m_en = '0;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int order [6];
    logic [NQ-1:0] one;
    order = '{0, 1, 2, 0, 1, 2};
    one   = 3'b001;
    model_reset();
    last_g = -1;

    // Reset held with every requester asking.
    #1 reset = 1'b0;
    req_valid = 3'b111;
    req_addr[0] = 5'd0;  req_addr[1] = 5'd3;  req_addr[2] = 5'd4;
    req_data[0] = 32'hA0A0_0000; req_data[1] = 32'h1111_1111; req_data[2] = 32'h2222_2222;
    @(negedge clock);
    cycle(1);
    #1 check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_count", 64'(wr_count), 64'(0));
    cycle(1);
    reset = 1'b1;
    #1 check("first_grant", 64'(req_ready), 64'(3'b001));
    cycle(1);

    // Single request from requester 1.
    req_valid = 3'b010;
    req_addr[1] = 5'd5;
    req_data[1] = 32'hDEAD_BEEF;
    #1 check("single_ready", 64'(req_ready), 64'(3'b010));
    cycle(1);
    req_valid = '0;
    #1 check("single_en", 64'(wr_enable), 64'(32'h20));
    check("single_data", 64'(wr_data), 64'(32'hDEAD_BEEF));
    check("single_src", 64'(wr_src), 64'(1));
    check("single_cnt", 64'(wr_count), 64'(1));
    cycle(1);
    #1 check("single_en_off", 64'(wr_enable), 64'(0));
    cycle(1);

    // Register 0 write from requester 2: consumed, never enabled.
    req_valid = 3'b100;
    req_addr[2] = 5'd0;
    req_data[2] = 32'h0000_1234;
    #1 check("r0_ready", 64'(req_ready), 64'(3'b100));
    cycle(1);
    req_valid = '0;
    #1 check("r0_en", 64'(wr_enable), 64'(0));
    check("r0_cnt", 64'(wr_count), 64'(1));
    check("r0_data", 64'(wr_data), 64'(32'h0000_1234));
    cycle(1);

    // Continuous round robin with distinct destinations.
    req_valid = 3'b111;
    req_addr[0] = 5'd10; req_addr[1] = 5'd11; req_addr[2] = 5'd12;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_order", 64'(req_ready), 64'(one << order[k]));
      cycle(1);
      if (last_g >= 0) req_addr[last_g] = req_addr[last_g] + 5'd3;
    end

    // Stall freezes the pointer; arbitration resumes from where it was.
    req_valid = 3'b101;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check("stall_ready", 64'(req_ready), 64'(0));
      cycle(1);
    end
    check("stall_no_en", 64'(wr_enable), 64'(0));
    stall = 1'b0;
    #1 check("post_stall_grant", 64'(req_ready), 64'(3'b001));
    cycle(1);
    req_valid[0] = 1'b0;

    // Randomized traffic; requesters hold their request until granted.
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          req_addr[i]  = 5'($urandom_range(0, 31));
          req_data[i]  = $urandom;
        end
      end
      cycle(1);
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end
    stall = 1'b0;

    // Drive the counter up to one below saturation.
    req_valid = 3'b111;
    req_addr[0] = 5'd7; req_addr[1] = 5'd8; req_addr[2] = 5'd9;
    for (int n = 0; n < 70000 && m_cnt != 16'hFFFE; n++) begin
      req_data[n % NQ] = $urandom;
      cycle(0);
    end
    #1 check("cnt_preload", 64'(wr_count), 64'(16'hFFFE));
    cycle(1);
    cycle(1);
    #1 check("cnt_sat", 64'(wr_count), 64'(16'hFFFF));
    cycle(1);
    #1 check("cnt_hold", 64'(wr_count), 64'(16'hFFFF));
    check("en_active", 64'(|wr_enable), 64'(1));

    // Asynchronous reset between edges clears the in-flight write at once.
    #1 reset = 1'b0;
    #1 check("async_en", 64'(wr_enable), 64'(0));
    check("async_cnt", 64'(wr_count), 64'(0));
    check("async_data", 64'(wr_data), 64'(0));
    check("async_src", 64'(wr_src), 64'(0));
    check("async_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(negedge clock);
    cycle(1);
    reset = 1'b1;
    #1 check("rerun_grant", 64'(req_ready), 64'(3'b001));
    cycle(1);
    cycle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
